// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the 4-bit LFSR pattern generator and
// its receive-side checker.
//   state_e      : checker synchronisation state (HUNT, VERIFY, LOCKED)
//   PRBS_W       : default LFSR width
//   PRBS_TAP_A/B : default feedback taps, feedback = reg[TAP_A] ^ reg[TAP_B]
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int PRBS_W     = 4;
  localparam int PRBS_TAP_A = 3;
  localparam int PRBS_TAP_B = 1;

endpackage : prbs_pkg

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : add one (holds at all-ones once saturated)
//   clr_i    : clear to zero; when inc_i is also high the result is 1,
//              so an event arriving with the clear is never lost
//   count_o  : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      if (clr_i) begin
        count_d = WIDTH'(1);
      end else if (count_q != '1) begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (clr_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the serial LFSR stream.
// Seeds a local LFSR from received bits (HUNT), confirms a run of matching
// bits (VERIFY), then free-runs and reports every mismatch (LOCKED).
//   clk, rst   : clock, synchronous active-high reset
//   din_valid  : qualifies din; nothing advances while low
//   din        : received serial bit
//   clr_cnt    : synchronous clear of err_count (a same-cycle error wins)
//   locked     : high while in LOCKED
//   err        : registered one-cycle pulse on a mismatch while LOCKED
//   err_count  : saturating count of mismatches while LOCKED
//   dbg_state  : current synchronisation state, for observation only
//
// Handshake: din is consumed on every rising edge of clk where din_valid
// is high; there is no backpressure, so the source never waits.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int W           = PRBS_W,
  parameter int TAP_A       = PRBS_TAP_A,
  parameter int TAP_B       = PRBS_TAP_B,
  parameter int LOCK_THRESH = 6,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output state_e           dbg_state
);

  localparam int FILL_W  = $clog2(W + 1);
  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  state_e             state_q, state_d;
  logic [W-1:0]       sreg_q, sreg_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               err_q, err_d;
  logic               cnt_inc;

  logic               exp_bit;
  logic               mismatch;
  logic [W-1:0]       shift_din;
  logic [W-1:0]       shift_exp;

  // Prediction always comes from the pre-shift register.
  assign exp_bit   = sreg_q[TAP_A] ^ sreg_q[TAP_B];
  assign mismatch  = din ^ exp_bit;
  assign shift_din = {sreg_q[W-2:0], din};
  // In LOCKED the register free-runs on its own prediction so one bad bit
  // on the line produces exactly one error rather than a burst.
  assign shift_exp = {sreg_q[W-2:0], exp_bit};

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_inc = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          sreg_d = shift_din;
          if (fill_q == FILL_W'(W - 1)) begin
            fill_d = '0;
            // An all-zero seed is the generator's lockup state: refill.
            if (shift_din != '0) begin
              state_d = VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end

        VERIFY: begin
          sreg_d = shift_din;
          if (!mismatch) begin
            if (match_q == MATCH_W'(LOCK_THRESH - 1)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            state_d = HUNT;
            fill_d  = '0;
          end
        end

        LOCKED: begin
          sreg_d = shift_exp;
          if (mismatch) begin
            err_d   = 1'b1;
            cnt_inc = 1'b1;
            if (miss_q == MISS_W'(LOSS_THRESH - 1)) begin
              state_d = HUNT;
              fill_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end

        default: begin
          state_d = HUNT;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sreg_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (cnt_inc),
    .clr_i  (clr_cnt),
    .count_o(err_count)
  );

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule : prbs_checker

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed bench for prbs_checker. Two instances share the
// stimulus: a 16-bit error counter and a 2-bit one for saturation. A
// bit-history model built from the recurrence of the stream is compared
// against both on every cycle, and literal checks pin key events.
module tb_prbs_checker;
  import prbs_pkg::*;

  localparam int W    = PRBS_W;
  localparam int TA   = PRBS_TAP_A;
  localparam int TB   = PRBS_TAP_B;
  localparam int LOCK = 6;
  localparam int LOSS = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic clr_cnt = 1'b0;

  always #5 clk = ~clk;

  logic        locked_w, err_w, locked_n, err_n;
  logic [15:0] cnt_w;
  logic [1:0]  cnt_n;
  state_e      st_w, st_n;

  prbs_checker #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked_w), .err(err_w), .err_count(cnt_w), .dbg_state(st_w)
  );

  prbs_checker #(.CNT_W(2)) u_dut_narrow (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked_n), .err(err_n), .err_count(cnt_n), .dbg_state(st_n)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hist holds the bits the local LFSR has absorbed, newest last; the
  // prediction is the XOR of the bits TAP_A and TAP_B positions back.
  bit     m_hist[$];
  state_e m_state;
  int     m_fill, m_match, m_miss, m_total;
  bit     m_err;
  bit     chk_en = 1'b0;

  function automatic bit last_w_zero();
    for (int i = 0; i < W; i++)
      if (m_hist[m_hist.size() - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(posedge clk) begin
    bit e;
    if (rst) begin
      m_hist = {};
      for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
      m_state = HUNT; m_fill = 0; m_match = 0; m_miss = 0; m_total = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (clr_cnt) m_total = 0;
      if (din_valid) begin
        e = m_hist[m_hist.size() - 1 - TA] ^ m_hist[m_hist.size() - 1 - TB];
        if (m_state == HUNT) begin
          m_hist.push_back(din);
          m_fill++;
          if (m_fill == W) begin
            m_fill = 0;
            if (!last_w_zero()) begin m_state = VERIFY; m_match = 0; end
          end
        end else if (m_state == VERIFY) begin
          m_hist.push_back(din);
          if (din == e) begin
            m_match++;
            if (m_match == LOCK) begin m_state = LOCKED; m_miss = 0; end
          end else begin
            m_state = HUNT; m_fill = 0;
          end
        end else begin
          m_hist.push_back(e);
          if (din != e) begin
            m_err = 1'b1; m_total++; m_miss++;
            if (m_miss == LOSS) begin m_state = HUNT; m_fill = 0; end
          end else begin
            m_miss = 0;
          end
        end
        while (m_hist.size() > W) void'(m_hist.pop_front());
      end
    end
  end

  // One compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("locked", locked_w, longint'(m_state == LOCKED));
      check("err", err_w, m_err);
      check("state", st_w, m_state);
      check("err_count", cnt_w, sat(m_total, 65535));
      check("locked_narrow", locked_n, longint'(m_state == LOCKED));
      check("err_narrow", err_n, m_err);
      check("state_narrow", st_n, m_state);
      check("err_count_narrow", cnt_n, sat(m_total, 3));
    end
  end

  // ---------------- driver tasks ----------------
  bit pat_a [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int n_bit = 0;

  task automatic cycle(input bit v, input bit d, input bit c, input bit r);
    @(negedge clk);
    din_valid = v; din = d; clr_cnt = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit flip, input bit c);
    bit b;
    b = pat_a[n_bit % 6] ^ flip;
    n_bit++;
    cycle(1'b1, b, c, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset for two cycles
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_locked", locked_w, 0);
    check("rst_count", cnt_w, 0);
    check("rst_state", st_w, HUNT);

    // lock acquisition: 4 fill + 6 verify
    n_bit = 0;
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 1'b0);
      if (i == 8) check("lock_bit9", locked_w, 0);
      if (i == 9) check("lock_bit10", locked_w, 1);
    end
    check("clean_count", cnt_w, 0);

    // single error
    for (int i = 0; i < 40; i++) begin
      send(i == 30, 1'b0);
      if (i == 30) begin
        check("single_err", err_w, 1);
        check("single_locked", locked_w, 1);
        check("single_count", cnt_w, 1);
      end
      if (i == 31) check("single_after", err_w, 0);
    end

    // loss of lock after three consecutive errors
    send(1'b0, 1'b1);
    check("clr_alone", cnt_w, 0);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0);
      if (i == 0) check("loss_hold", locked_w, 1);
      if (i == 2) begin
        check("loss_err", err_w, 1);
        check("loss_locked", locked_w, 0);
        check("loss_count", cnt_w, 3);
      end
    end
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 1'b0);
      if (i == 8) check("relock_bit9", locked_w, 0);
      if (i == 9) check("relock_bit10", locked_w, 1);
    end

    // lockup rejection: all zeros never seed
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("zeros_locked", locked_w, 0);
    check("zeros_state", st_w, HUNT);
    // two pattern zeros complete a zero fill; seed is bits 2..5
    n_bit = 0;
    for (int i = 0; i < 12; i++) begin
      send(1'b0, 1'b0);
      if (i == 10) check("seed_bit11", locked_w, 0);
      if (i == 11) check("seed_bit12", locked_w, 1);
    end

    // valid gaps with junk on din
    for (int i = 0; i < 40; i++) begin
      int g;
      g = $urandom_range(0, 5);
      repeat (g) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      send(1'b0, 1'b0);
    end
    check("gap_locked", locked_w, 1);
    check("gap_count", cnt_w, 0);

    // five isolated errors: wide counts 5, narrow saturates at 3
    for (int e = 0; e < 5; e++) begin
      send(1'b1, 1'b0);
      repeat (5) send(1'b0, 1'b0);
    end
    check("iso_count", cnt_w, 5);
    check("iso_count_narrow", cnt_n, 3);
    check("iso_locked", locked_w, 1);

    // clear together with an error: error wins
    send(1'b1, 1'b1);
    check("clr_err_count", cnt_w, 1);
    check("clr_err_narrow", cnt_n, 1);
    send(1'b0, 1'b1);
    check("clr_only", cnt_w, 0);

    // reset while locked
    send(1'b1, 1'b0);
    check("pre_rst_count", cnt_w, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_rst_locked", locked_w, 0);
    check("mid_rst_count", cnt_w, 0);
    check("mid_rst_narrow", cnt_n, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prbs_checker

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side checker for the serial bit stream produced by the team's 4-bit LFSR pattern generator.
- Self-synchronises to the incoming stream by seeding a local LFSR from received bits, then confirms lock.
- Once locked, free-runs the local LFSR and flags and counts every bit mismatch.
- Sits at the sink of BIST and link-test paths.

Parameters:
- W, 4, LFSR width in bits.
- TAP_A, 3, first feedback tap index.
- TAP_B, 1, second feedback tap index. Feedback bit = reg[TAP_A] ^ reg[TAP_B].
- LOCK_THRESH, 6, consecutive matching bits required in VERIFY before declaring lock.
- LOSS_THRESH, 3, consecutive mismatches in LOCKED that drop lock.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- din_valid  in  1  qualifies din; all state holds while low.
- din  in  1  received serial bit.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse, registered, on a mismatch while LOCKED.
- err_count  out  CNT_W  saturating count of mismatches while LOCKED.

Behaviour:
- Reset values:
  - state = HUNT; shift reg = 0; fill_cnt = 0; match_cnt = 0; miss_cnt = 0.
  - locked = 0; err = 0; err_count = 0.
- Shift rule, applied on each valid bit: reg <= {reg[W-2:0], b}. The expected bit is reg[TAP_A] ^ reg[TAP_B], taken from the pre-shift reg.
- HUNT:
  - Each valid bit: shift in din; fill_cnt++.
  - When the W-th bit is shifted in, evaluate the new reg value.
  - New reg == 0 (generator lockup state): stay in HUNT and restart the fill.
  - Otherwise: go to VERIFY with match_cnt = 0.
- VERIFY:
  - Each valid bit: shift in din (self-synchronous).
  - din == expected: match_cnt++. At LOCK_THRESH, go to LOCKED; locked rises on the same edge.
  - Mismatch: go to HUNT, fill_cnt = 0, reg keeps shifting.
  - No err pulse and no counting in this state.
- LOCKED:
  - Each valid bit: shift in the expected bit, not din (free-run, no error multiplication).
  - Mismatch: err = 1 for that cycle; err_count++ (saturating at all-ones); miss_cnt++.
  - Match: miss_cnt = 0.
  - miss_cnt reaching LOSS_THRESH: go to HUNT with fill_cnt = 0. locked falls on the same edge as the err pulse of the LOSS_THRESH-th mismatch.
- din_valid low: no state, reg or counter change; err = 0.
- Latency: err and locked change on the clock edge that samples the relevant valid bit (one-cycle registered latency).
- clr_cnt:
  - Alone: err_count <= 0.
  - Together with a counted error on the same cycle: err_count <= 1 (the error wins over the clear).
- Reset mid-operation: returns to the reset state on the next edge; err_count is cleared.
- Default sequence: the generator seeded 0xE emits the period-6 pattern 0,0,1,1,1,1 repeating on out[0].

Decomposition:
- Package prbs_pkg:
  - state enum {HUNT, VERIFY, LOCKED}.
  - Default W/TAP_A/TAP_B constants, shared with the generator.
- One sub-module: sat_counter (parameterised width; inc, clr, saturate; inc beats clr). Used for err_count.

Test Plan:
- Lock acquisition: rst for 2 cycles, then din = 001111 repeating, din_valid = 1 → locked rises at the edge sampling the 10th bit (4 fill + 6 verify); err never pulses; err_count = 0 after 100 bits.
- Single error: after lock, invert bit 30 → one err pulse; err_count = 1; locked stays 1; subsequent bits match.
- Loss of lock: after lock, invert 3 consecutive bits → err pulses 3 times; err_count = 3; locked falls with the 3rd pulse; clean stream resumes and relocks 10 valid bits later.
- Lockup rejection: din = all zeros for 50 bits → locked stays 0; state stays in HUNT. Then the correct pattern → lock within 10 bits of the first valid seed.
- Valid gaps: locked stream with din_valid low for 1-5 cycles at random, holding din junk during gaps → no err pulses; locked stays 1; err_count = 0.
- Counter control: preload via CNT_W = 2, inject 5 isolated errors → err_count saturates at 3. clr_cnt coincident with an error → err_count = 1. rst while locked → locked = 0 and err_count = 0 next edge.
